// File: rtl/snake_game_ctrl.sv
// Snake game controller: button edges to direction, programmable move tick,
// and per-tick wall / food resolution into move, grow or sticky death.
module snake_game_ctrl #(
  parameter int unsigned TICK_DIV = 5_000_000,
  parameter int unsigned X_MAX    = 500,
  parameter int unsigned Y_MAX    = 460,
  parameter int unsigned MAX_LEN  = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  input  logic [8:0] head_x,
  input  logic [8:0] head_y,
  input  logic [8:0] food_x,
  input  logic [8:0] food_y,
  output logic [1:0] dir,
  output logic       move,
  output logic       grow,
  output logic       food_eaten,
  output logic       dead,
  output logic [4:0] length,
  output logic       running
);

  localparam int unsigned     CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [8:0]      X_LIM     = 9'(X_MAX);
  localparam logic [8:0]      Y_LIM     = 9'(Y_MAX);
  localparam logic [4:0]      LEN_SAT   = 5'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       pend_dir_r;
  // bit order: {start, up, left, down, right}
  logic [4:0]       btn_cur_r;
  logic [4:0]       btn_prev_r;
  logic [4:0]       btn_edge_s;
  logic [1:0]       req_dir_s;
  logic             req_valid_s;
  logic             req_ok_s;
  logic             tick_s;
  logic             wall_s;
  logic             hit_s;

  assign btn_edge_s = btn_cur_r & ~btn_prev_r;
  assign req_ok_s   = req_valid_s && (req_dir_s != (dir ^ 2'd2));
  assign tick_s     = (state_r == ST_RUN) && (cnt_r == TICK_LAST);
  // Underflowed coordinates wrap high and are caught by the same compare.
  assign wall_s     = (head_x > X_LIM) || (head_y > Y_LIM);
  assign hit_s      = (head_x == food_x) && (head_y == food_y);

  // Button edge registers; preset high so a button held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_cur_r  <= 5'b11111;
      btn_prev_r <= 5'b11111;
    end else begin
      btn_cur_r  <= {btn_start, btn_up, btn_left, btn_down, btn_right};
      btn_prev_r <= btn_cur_r;
    end
  end

  // Direction request priority: right > down > left > up.
  always_comb begin
    req_valid_s = 1'b0;
    req_dir_s   = 2'd0;
    if (btn_edge_s[0]) begin
      req_valid_s = 1'b1;
      req_dir_s   = 2'd0;
    end else if (btn_edge_s[1]) begin
      req_valid_s = 1'b1;
      req_dir_s   = 2'd1;
    end else if (btn_edge_s[2]) begin
      req_valid_s = 1'b1;
      req_dir_s   = 2'd2;
    end else if (btn_edge_s[3]) begin
      req_valid_s = 1'b1;
      req_dir_s   = 2'd3;
    end else begin
      req_valid_s = 1'b0;
      req_dir_s   = 2'd0;
    end
  end

  // Game FSM with tick counter and registered action outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      pend_dir_r <= 2'd0;
      dir        <= 2'd0;
      move       <= 1'b0;
      grow       <= 1'b0;
      food_eaten <= 1'b0;
      dead       <= 1'b0;
      length     <= 5'd0;
      running    <= 1'b0;
    end else begin
      move       <= 1'b0;
      grow       <= 1'b0;
      food_eaten <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (btn_edge_s[4]) begin
            state_r <= ST_RUN;
            running <= 1'b1;
            cnt_r   <= '0;
          end
        end
        ST_RUN: begin
          // A request in the tick cycle lands in pend_dir after dir has sampled it.
          if (req_ok_s) begin
            pend_dir_r <= req_dir_s;
          end
          if (tick_s) begin
            cnt_r <= '0;
            if (wall_s) begin
              state_r <= ST_DEAD;
              dead    <= 1'b1;
              running <= 1'b0;
            end else begin
              dir <= pend_dir_r;
              if (hit_s) begin
                food_eaten <= 1'b1;
                if (length < LEN_SAT) begin
                  grow   <= 1'b1;
                  length <= length + 5'd1;
                end else begin
                  move <= 1'b1;
                end
              end else begin
                move <= 1'b1;
              end
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DEAD: begin
          state_r <= ST_DEAD;
        end
        default: begin
          state_r <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl: driver queues expected pulses with
// their cycle; a negedge monitor pops and compares on every action pulse.
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right, btn_start;
  logic [8:0] head_x, head_y, food_x, food_y;
  logic [1:0] dir;
  logic       move, grow, food_eaten, dead, running;
  logic [4:0] length;

  snake_game_ctrl #(.TICK_DIV(4), .X_MAX(500), .Y_MAX(460), .MAX_LEN(31)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_start(btn_start),
    .head_x(head_x), .head_y(head_y), .food_x(food_x), .food_y(food_y),
    .dir(dir), .move(move), .grow(grow), .food_eaten(food_eaten),
    .dead(dead), .length(length), .running(running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       mv;
    logic       gr;
    logic       fe;
    logic [1:0] d;
    logic [4:0] l;
  } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int run_base;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic mv, input logic gr, input logic fe,
                      input logic [1:0] d, input logic [4:0] l);
    exp_t e;
    e.cyc = c; e.mv = mv; e.gr = gr; e.fe = fe; e.d = d; e.l = l;
    q.push_back(e);
  endtask

  // Expected cycle of the m-th action pulse after RUN entry.
  function automatic int pc(input int m);
    return run_base + 4 * m;
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) next();
  endtask

  // One-cycle press; which = {up, left, down, right}.
  task automatic press(input int c, input logic [3:0] which);
    go_to(c);
    {btn_up, btn_left, btn_down, btn_right} = which;
    next();
    {btn_up, btn_left, btn_down, btn_right} = 4'b0000;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dir"}, 64'(dir), 64'd0);
    chk({tag, "_pulses"}, 64'({move, grow, food_eaten}), 64'd0);
    chk({tag, "_dead"}, 64'(dead), 64'd0);
    chk({tag, "_length"}, 64'(length), 64'd0);
    chk({tag, "_running"}, 64'(running), 64'd0);
  endtask

  // Monitor: every action pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (move || grow || food_eaten) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 64'({move, grow, food_eaten}), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse", {22'd0, 32'(cyc), move, grow, food_eaten, dir, length},
                     {22'd0, 32'(e.cyc), e.mv, e.gr, e.fe, e.d, e.l});
      end
    end
  end

  initial begin
    rst = 1'b1;
    {btn_up, btn_down, btn_left, btn_right, btn_start} = 5'b00000;
    head_x = 9'd300; head_y = 9'd300; food_x = 9'd0; food_y = 9'd0;
    repeat (3) next();
    rst = 1'b0;
    check_reset_vals("reset");

    // Start: running rises two edges after btn_start is sampled.
    next();
    btn_start = 1'b1;
    run_base = cyc + 2;
    next();
    btn_start = 1'b0;
    chk("running_early", 64'(running), 64'd0);
    next();
    chk("running_on", 64'(running), 64'd1);

    push(pc(1), 1'b1, 1'b0, 1'b0, 2'd0, 5'd0);
    push(pc(2), 1'b1, 1'b0, 1'b0, 2'd0, 5'd0);
    push(pc(3), 1'b1, 1'b0, 1'b0, 2'd0, 5'd0);
    press(pc(2), 4'b0100);                   // left: reversal of right, dropped
    push(pc(4), 1'b1, 1'b0, 1'b0, 2'd1, 5'd0);
    press(pc(3), 4'b0010);                   // down
    push(pc(5), 1'b1, 1'b0, 1'b0, 2'd0, 5'd0);
    press(pc(4), 4'b0001);                   // right
    push(pc(6), 1'b1, 1'b0, 1'b0, 2'd3, 5'd0);
    go_to(pc(5));                            // up then left within one tick
    btn_up = 1'b1;
    next();
    btn_up = 1'b0; btn_left = 1'b1;
    next();
    btn_left = 1'b0;
    push(pc(7), 1'b1, 1'b0, 1'b0, 2'd3, 5'd0);
    push(pc(8), 1'b1, 1'b0, 1'b0, 2'd0, 5'd0);
    press(pc(7) - 2, 4'b0001);               // edge lands in tick cycle: next tick
    push(pc(9), 1'b1, 1'b0, 1'b0, 2'd1, 5'd0);
    press(pc(8), 4'b0110);                   // left+down together: down wins

    // Food on head for 32 ticks: grow to 31, then move while eating.
    go_to(pc(9));
    head_x = 9'd320; food_x = 9'd320; food_y = 9'd300;
    for (int i = 1; i <= 32; i++) begin
      push(pc(9 + i), (i == 32), (i <= 31), 1'b1, 2'd1, (i <= 31) ? 5'(i) : 5'd31);
    end
    go_to(pc(41));
    food_x = 9'd0; food_y = 9'd0;
    push(pc(42), 1'b1, 1'b0, 1'b0, 2'd1, 5'd31);

    // Wall hit.
    go_to(pc(42));
    head_x = 9'd508;
    go_to(pc(43));
    chk("dead_set", 64'(dead), 64'd1);
    chk("dead_running", 64'(running), 64'd0);
    chk("dead_pulses", 64'({move, grow, food_eaten}), 64'd0);
    chk("dead_length", 64'(length), 64'd31);
    btn_start = 1'b1; btn_right = 1'b1;
    next();
    btn_start = 1'b0; btn_right = 1'b0;
    go_to(pc(46));
    chk("dead_hold", 64'({dead, running, dir, length}), 64'({1'b1, 1'b0, 2'd1, 5'd31}));
    chk("queue_drained_1", 64'(q.size()), 64'd0);
    rst = 1'b1;
    next();
    rst = 1'b0;
    check_reset_vals("dead_rst");

    // Mid-run reset in the tick cycle, with food on head.
    head_x = 9'd300; head_y = 9'd300;
    next();
    btn_start = 1'b1;
    run_base = cyc + 2;
    next();
    btn_start = 1'b0;
    push(pc(1), 1'b1, 1'b0, 1'b0, 2'd0, 5'd0);
    go_to(pc(2) - 1);
    food_x = 9'd300; food_y = 9'd300;
    rst = 1'b1;
    next();
    rst = 1'b0;
    check_reset_vals("midrun_rst");
    repeat (12) next();
    chk("idle_after_rst", 64'({running, length}), 64'd0);
    chk("queue_drained_2", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
